ysyx_22040237_lsu: RTL and testbench
====================================

// Module: ysyx_22040237_lsu
// PURPOSE
//  Multi-cycle load/store unit directly downstream of the execute stage. Takes the EXU
//  result (effective address or ALU value) plus store data, runs one data-memory access
//  over a req/gnt/rvalid bus, and hands an aligned, extended result to writeback.
//  Non-memory ops pass through with one cycle of latency.
// PARAMETERS
//  ADDR_W   32    address width
//  DATA_W   64    data / bus width (fixed at 64; 8 byte lanes)
//  TIMEOUT  255   max cycles in REQ or WAIT before bus-timeout exception
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-low
//  in_valid     in   1       EXU result valid
//  in_ready     out  1       LSU can accept (IDLE only)
//  in_load      in   1       load op
//  in_store     in   1       store op
//  in_size      in   2       0=byte 1=half 2=word 3=dword
//  in_unsigned  in   1       zero-extend load (lbu/lhu/lwu)
//  in_addr      in   ADDR_W  effective address / unused for non-mem
//  in_wdata     in   64      store data, LSB-justified
//  in_alu       in   64      ALU result for pass-through ops
//  mem_req      out  1       bus request
//  mem_we       out  1       1=write
//  mem_addr     out  ADDR_W  8-byte-aligned address (in_addr & ~7)
//  mem_wdata    out  64      store data shifted to byte lane
//  mem_wmask    out  8       byte enables
//  mem_gnt      in   1       request accepted this cycle
//  mem_rvalid   in   1       read data valid
//  mem_rdata    in   64      read data
//  out_valid    out  1       result valid to writeback
//  out_ready    in   1       writeback accepts
//  out_data     out  64      load data / ALU value / 0 for store
//  out_exc      out  2       0=none 1=misaligned 2=bus timeout 3=load&store both set
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, counter=0; all outputs 0 except in_ready=1.
//  FSM IDLE -> REQ -> WAIT -> RESP -> IDLE:
//   IDLE: in_ready=1. On in_valid, capture all inputs. Then:
//     load&store -> RESP exc=3; misaligned -> RESP exc=1 (no bus access);
//     neither -> RESP, out_data=in_alu; else -> REQ.
//     Misaligned: half addr[0]!=0; word addr[1:0]!=0; dword addr[2:0]!=0.
//   REQ: mem_req=1; mem_we/addr/wdata/wmask held stable until mem_gnt.
//     On gnt: store -> RESP, out_data=0; load -> WAIT.
//   WAIT: mem_rvalid in REQ is ignored; rvalid arrives >=1 cycle after gnt.
//     On rvalid: sh=addr[2:0]*8; d=rdata>>sh; truncate to size;
//     sign-extend unless in_unsigned; -> RESP.
//   RESP: out_valid=1, out_data/out_exc held until out_ready; then -> IDLE.
//     No new capture in the RESP->IDLE cycle.
//  Store lanes: mem_wmask=({1,3,15,255}[size])<<addr[2:0];
//   mem_wdata=in_wdata<<(addr[2:0]*8); masked-off lanes don't-care.
//  Timeout: counter clears on entering REQ and WAIT and increments each cycle there.
//   At TIMEOUT without gnt/rvalid -> RESP exc=2, out_data=0, mem_req dropped.
//  Latency: pass-through/exception 1 cycle to out_valid. Store with same-cycle gnt
//   gives 2; load with gnt then rvalid next cycle gives 3.
//  rst low in any state aborts: next cycle IDLE, mem_req=0. A stale rvalid
//   then arrives in IDLE and is ignored.
// TESTING
//  sw addr=0x80000004 wdata=0x11223344, gnt same cycle -> mem_addr=0x80000000,
//   wmask=0xF0, wdata[63:32]=0x11223344, out_valid 2 cycles after capture, exc=0.
//  lb addr=0x80000003, rdata=0x0000_0000_8000_0000 -> out_data=0xFFFF_FFFF_FFFF_FF80;
//   same with lbu -> 0x80; ld addr=0x80000008 -> full rdata.
//  lw addr=0x80000002 -> exc=1 next cycle, mem_req never asserted.
//  gnt held low 3 cycles -> req/addr/wmask stable; TIMEOUT=8, no rvalid -> exc=2.
//  out_ready low 5 cycles in RESP -> out_valid/out_data/out_exc stable, in_ready=0.
//  rst low during WAIT -> IDLE, mem_req=0; rvalid pulse afterwards gives no out_valid.

Source files
------------

// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu: multi-cycle load/store unit between execute and writeback.
// Runs one req/gnt/rvalid data-memory access per op; non-memory ops pass through.
`default_nettype none

module ysyx_22040237_lsu #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [DATA_W-1:0] in_alu,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_exc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              store_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        exc_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              w_misal;
    logic [1:0]        w_exc_in;
    logic [7:0]        w_mask_base;
    logic              w_timeout;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_ldata;

    always_comb begin
        w_misal     = 1'b0;
        w_mask_base = 8'h01;
        case (in_size)
            2'd0: begin w_misal = 1'b0;            w_mask_base = 8'h01; end
            2'd1: begin w_misal = in_addr[0];      w_mask_base = 8'h03; end
            2'd2: begin w_misal = |in_addr[1:0];   w_mask_base = 8'h0F; end
            default: begin w_misal = |in_addr[2:0]; w_mask_base = 8'hFF; end
        endcase
    end

    // Conflicting load/store flags outrank alignment.
    always_comb begin
        w_exc_in = 2'd0;
        if (in_load && in_store)
            w_exc_in = 2'd3;
        else if ((in_load || in_store) && w_misal)
            w_exc_in = 2'd1;
    end

    assign w_timeout = (cnt_q == CNT_W'(TIMEOUT));
    assign w_shifted = mem_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        w_ldata = w_shifted;
        case (size_q)
            2'd0: w_ldata = {{56{~uns_q & w_shifted[7]}},  w_shifted[7:0]};
            2'd1: w_ldata = {{48{~uns_q & w_shifted[15]}}, w_shifted[15:0]};
            2'd2: w_ldata = {{32{~uns_q & w_shifted[31]}}, w_shifted[31:0]};
            default: w_ldata = w_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (w_exc_in != 2'd0 || !(in_load || in_store))
                        state_d = S_RESP;
                    else
                        state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt)
                    state_d = store_q ? S_RESP : S_WAIT;
                else if (w_timeout)
                    state_d = S_RESP;
            end
            S_WAIT: begin
                if (mem_rvalid || w_timeout)
                    state_d = S_RESP;
            end
            default: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = 8'h00;
        out_valid = 1'b0;
        out_data  = '0;
        out_exc   = 2'd0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_REQ: begin
                mem_req   = 1'b1;
                mem_we    = store_q;
                mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
                mem_wdata = wdata_q;
                mem_wmask = store_q ? wmask_q : 8'h00;
            end
            S_RESP: begin
                out_valid = 1'b1;
                out_data  = data_q;
                out_exc   = exc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            store_q <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            data_q  <= '0;
            exc_q   <= 2'd0;
            cnt_q   <= '0;
        end else begin
            // The counter restarts on every state change, so REQ and WAIT each get a full budget.
            if (state_d != state_q || !(state_q == S_REQ || state_q == S_WAIT))
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        store_q <= in_store;
                        uns_q   <= in_unsigned;
                        size_q  <= in_size;
                        addr_q  <= in_addr;
                        wdata_q <= in_wdata << {in_addr[2:0], 3'b000};
                        wmask_q <= w_mask_base << in_addr[2:0];
                        data_q  <= (in_load || in_store) ? '0 : in_alu;
                        exc_q   <= w_exc_in;
                    end
                end
                S_REQ: begin
                    if (!mem_gnt && w_timeout)
                        exc_q <= 2'd2;
                end
                S_WAIT: begin
                    if (mem_rvalid)
                        data_q <= w_ldata;
                    else if (w_timeout)
                        exc_q <= 2'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_lsu.sv
// tb_ysyx_22040237_lsu: directed and randomized checks of the LSU against a byte-level model.
`default_nettype none

module tb_ysyx_22040237_lsu;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic [63:0] in_alu;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [1:0]  out_exc;

    int ncmp = 0;
    int nfail = 0;

    ysyx_22040237_lsu #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_alu(in_alu),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic logic [1:0] ref_exc(input logic ld, st, input logic [1:0] sz,
                                           input logic [31:0] a);
        if (ld && st) return 2'd3;
        if ((ld || st) && (a % nbytes(sz)) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [7:0] ref_mask(input logic [1:0] sz, input logic [31:0] a);
        logic [7:0] m = 8'h00;
        int off = int'(a % 8);
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + nbytes(sz)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [63:0] wd);
        logic [63:0] r = '0;
        int off = int'(a % 8);
        for (int i = 0; i < 8; i++)
            if (i >= off && i < off + nbytes(sz)) r[i*8 +: 8] = wd[(i-off)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] lane_bits(input logic [7:0] m);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (m[i]) r[i*8 +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [63:0] rd);
        longint unsigned v = 0;
        int off = int'(a % 8);
        int n = nbytes(sz);
        for (int j = 0; j < n; j++)
            v = v + (longint'(rd[(off+j)*8 +: 8]) << (8*j));
        if (!uns && n < 8 && ((v >> (8*n - 1)) & 1) == 1)
            v = v - (64'd1 << (8*n));
        return v;
    endfunction

    // ---------------- one full transaction ----------------
    task automatic run_op(input string tag, input logic ld, st, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [63:0] wd,
                          input logic [63:0] alu, input logic [63:0] rd,
                          input int gd, input int rvd, input int ryd);
        logic [1:0]  e_exc  = ref_exc(ld, st, sz, a);
        logic [63:0] e_data;
        logic [63:0] lanes  = lane_bits(ref_mask(sz, a));
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
        in_addr = a; in_wdata = wd; in_alu = alu;
        step();
        in_valid = 1'b0; in_wdata = $urandom; in_alu = {$urandom, $urandom};
        in_addr = $urandom; in_size = 2'($urandom);
        if (e_exc != 2'd0)              e_data = 64'd0;
        else if (!ld && !st)            e_data = alu;
        else if (st)                    e_data = 64'd0;
        else                            e_data = ref_load(sz, uns, a, rd);
        if (e_exc == 2'd0 && (ld || st)) begin
            for (int k = 0; k <= gd; k++) begin
                check({tag, "_req"}, {63'd0, mem_req}, 64'd1);
                check({tag, "_we"}, {63'd0, mem_we}, {63'd0, st});
                check({tag, "_addr"}, {32'd0, mem_addr}, {32'd0, a & 32'hFFFF_FFF8});
                if (st) begin
                    check({tag, "_wmask"}, {56'd0, mem_wmask}, {56'd0, ref_mask(sz, a)});
                    check({tag, "_wdata"}, mem_wdata & lanes, ref_wdata(sz, a, wd));
                end
                mem_gnt    = (k == gd);
                mem_rvalid = (k != gd) ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
            end
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (ld) begin
                for (int k = 0; k < rvd; k++) begin
                    check({tag, "_wait_noreq"}, {63'd0, mem_req}, 64'd0);
                    check({tag, "_wait_nov"}, {63'd0, out_valid}, 64'd0);
                    step();
                end
                mem_rvalid = 1'b1; mem_rdata = rd;
                step();
                mem_rvalid = 1'b0; mem_rdata = {$urandom, $urandom};
            end
        end else begin
            check({tag, "_noreq"}, {63'd0, mem_req}, 64'd0);
        end
        check({tag, "_ovalid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_odata"}, out_data, e_data);
        check({tag, "_oexc"}, {62'd0, out_exc}, {62'd0, e_exc});
        for (int k = 0; k < ryd; k++) begin
            step();
            check({tag, "_hold_v"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_hold_d"}, out_data, e_data);
            check({tag, "_hold_e"}, {62'd0, out_exc}, {62'd0, e_exc});
            check({tag, "_hold_rdy"}, {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_done_v"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int reqcyc;
        int waited;
        rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0;
        in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_alu = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        rst = 1'b1;
        step();

        // Directed cases from the datasheet examples.
        run_op("sw", 0, 1, 2'd2, 0, 32'h8000_0004, 64'h1122_3344, 0, 0, 0, 0, 0);
        run_op("lb", 1, 0, 2'd0, 0, 32'h8000_0003, 64'h0, 0, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_op("lbu", 1, 0, 2'd0, 1, 32'h8000_0003, 64'h0, 0, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_op("ld", 1, 0, 2'd3, 0, 32'h8000_0008, 64'h0, 0, 64'hDEAD_BEEF_0123_4567, 1, 2, 0);
        run_op("lw_mis", 1, 0, 2'd2, 0, 32'h8000_0002, 64'h0, 0, 0, 0, 0, 0);
        run_op("alu", 0, 0, 2'd3, 0, 32'h0, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 0, 0, 0);
        run_op("both", 1, 1, 2'd0, 0, 32'h8000_0000, 64'h0, 64'h55, 0, 0, 0, 0);
        run_op("sb_gnt3", 0, 1, 2'd0, 0, 32'h8000_0007, 64'hA5, 0, 0, 3, 0, 5);
        run_op("lh_neg", 1, 0, 2'd1, 0, 32'h8000_0006, 64'h0, 0, 64'h8001_0000_0000_0000, 0, 1, 0);

        // Bus timeout in REQ: grant never comes.
        in_valid = 1'b1; in_load = 1'b0; in_store = 1'b1; in_size = 2'd3;
        in_addr = 32'h8000_0010; in_wdata = 64'h1;
        step();
        in_valid = 1'b0;
        reqcyc = 0;
        waited = 0;
        while (!out_valid && waited < 40) begin
            if (waited < 3) begin
                check("to_req_stable", {63'd0, mem_req}, 64'd1);
                check("to_addr_stable", {32'd0, mem_addr}, 64'h8000_0010);
                check("to_mask_stable", {56'd0, mem_wmask}, 64'hFF);
            end
            if (mem_req) reqcyc++;
            step();
            waited++;
        end
        check("to_out_valid", {63'd0, out_valid}, 64'd1);
        check("to_len_in_range", {63'd0, (reqcyc >= TO && reqcyc <= TO + 2)}, 64'd1);
        check("to_exc", {62'd0, out_exc}, 64'd2);
        check("to_data", out_data, 64'd0);
        check("to_req_dropped", {63'd0, mem_req}, 64'd0);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Bus timeout in WAIT: granted load, no read data.
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd3;
        in_addr = 32'h8000_0020;
        step();
        in_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        waited = 0;
        while (!out_valid && waited < 40) begin
            step();
            waited++;
        end
        check("tow_out_valid", {63'd0, out_valid}, 64'd1);
        check("tow_len_in_range", {63'd0, (waited >= TO && waited <= TO + 2)}, 64'd1);
        check("tow_exc", {62'd0, out_exc}, 64'd2);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Reset abort during WAIT, then a stale rvalid.
        in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd2;
        in_addr = 32'h8000_0040;
        step();
        in_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("abort_req", {63'd0, mem_req}, 64'd0);
        check("abort_ready", {63'd0, in_ready}, 64'd1);
        mem_rvalid = 1'b1; mem_rdata = 64'h1234;
        step();
        mem_rvalid = 1'b0;
        check("stale_rvalid_v", {63'd0, out_valid}, 64'd0);
        step();
        check("stale_rvalid_v2", {63'd0, out_valid}, 64'd0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            int r = $urandom_range(0, 9);
            logic ld = (r == 0) || (r >= 2 && r <= 5);
            logic st = (r == 0) || (r >= 6);
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [31:0] a = 32'h8000_0000 | ($urandom & 32'hFFF);
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 1);
            run_op("rnd", ld, st, sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire
